dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 119 +++++++++++
 tb/tb_dmem_responder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: fixed-latency word memory with a registered
// one-cycle completion pulse and misaligned-access detection.
module dmem_responder #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 64,
    parameter int WAITCYC = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic             we,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] wd,
    output logic [WIDTH-1:0] rd,
    output logic             ready,
    output logic             err,
    output logic             busy,
    output logic             stall
);
    localparam int IW = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = 4'(WAITCYC - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [IW+1:0]    addr_q, addr_d;
    logic [WIDTH-1:0] wd_q, wd_d;
    logic [WIDTH-1:0] rd_q, rd_d;
    logic             ready_q, ready_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [IW-1:0]    idx;
    logic             mis;
    logic             mem_we;
    logic             unused_addr;

    // Upper address bits alias onto the same words.
    assign unused_addr = ^addr[WIDTH-1:IW+2];
    assign idx         = addr_q[IW+1:2];
    assign mis         = |addr_q[1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wd_d    = wd_q;
        rd_d    = rd_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        mem_we  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    we_d    = we;
                    addr_d  = addr[IW+1:0];
                    wd_d    = wd;
                    cnt_d   = CNT_INIT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    ready_d = 1'b1;
                    err_d   = mis;
                    if (mis || we_q) begin
                        rd_d = '0;
                    end else begin
                        rd_d = mem[idx];
                    end
                    mem_we = we_q & ~mis;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wd_q    <= '0;
            rd_q    <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            rd_q    <= rd_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    // Memory keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx] <= wd_q;
        end
    end

    assign rd    = rd_q;
    assign ready = ready_q;
    assign err   = err_q;
    assign busy  = (state_q != IDLE);
    assign stall = req & ~ready_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: WAITCYC=2 and WAITCYC=1 instances.
module tb_dmem_responder;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        req, we, ready, err, busy, stall;
    logic [31:0] addr, wd, rd;
    logic        req1, we1, ready1, err1, busy1, stall1;
    logic [31:0] addr1, wd1, rd1;

    dmem_responder #(.WIDTH(32), .DEPTH(64), .WAITCYC(2)) u_dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr),
        .wd(wd), .rd(rd), .ready(ready), .err(err), .busy(busy),
        .stall(stall)
    );

    dmem_responder #(.WIDTH(32), .DEPTH(64), .WAITCYC(1)) u_dut1 (
        .clk(clk), .reset(reset), .req(req1), .we(we1), .addr(addr1),
        .wd(wd1), .rd(rd1), .ready(ready1), .err(err1), .busy(busy1),
        .stall(stall1)
    );

    typedef struct packed {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic exp_t mk(input logic [31:0] r, input logic e);
        exp_t x;
        x.rd  = r;
        x.err = e;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ready === 1'b1) begin
            if (q0.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL dut0 spurious ready: got 1 want 0");
            end else begin
                exp_t e;
                e = q0.pop_front();
                chk("dut0 rd", rd, e.rd);
                chk("dut0 err", 32'(err), 32'(e.err));
            end
        end
    end

    always @(negedge clk) begin
        if (ready1 === 1'b1) begin
            if (q1.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL dut1 spurious ready: got 1 want 0");
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("dut1 rd", rd1, e.rd);
                chk("dut1 err", 32'(err1), 32'(e.err));
            end
        end
    end

    task automatic xact0(input string nm, input logic w,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] erd, input logic eerr,
                         input bit scramble);
        int lat;
        req  = 1'b1;
        we   = w;
        addr = a;
        wd   = d;
        q0.push_back(mk(erd, eerr));
        @(posedge clk); #1;
        chk({nm, " busy"}, 32'(busy), 32'd1);
        if (scramble) begin
            addr = a ^ 32'h8;
            wd   = ~d;
        end
        lat = 0;
        while (ready !== 1'b1 && lat < 20) begin
            chk({nm, " stall"}, 32'(stall), 32'd1);
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, " latency"}, 32'(lat), 32'd2);
        chk({nm, " stall@ready"}, 32'(stall), 32'd0);
        req = 1'b0;
        we  = 1'b0;
        @(posedge clk); #1;
        chk({nm, " idle"}, 32'(busy), 32'd0);
    endtask

    task automatic xact1(input string nm, input logic w,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] erd);
        int lat;
        req1  = 1'b1;
        we1   = w;
        addr1 = a;
        wd1   = d;
        q1.push_back(mk(erd, 1'b0));
        @(posedge clk); #1;
        lat = 0;
        while (ready1 !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, " latency"}, 32'(lat), 32'd1);
        req1 = 1'b0;
        we1  = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        bit pulse;
        reset = 1'b1;
        req = 1'b0; we = 1'b0; addr = '0; wd = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wd1 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset rd", rd, 32'd0);
        chk("reset ready", 32'(ready), 32'd0);
        chk("reset err", 32'(err), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        reset = 1'b0;

        xact0("wr10", 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
        xact0("rd10", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
        xact0("wr13 mis", 1'b1, 32'h13, 32'h12345678, 32'h0, 1'b1, 1'b0);
        xact0("rd10 again", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);

        xact0("wr20 init", 1'b1, 32'h20, 32'h11111111, 32'h0, 1'b0, 1'b0);
        req = 1'b1; we = 1'b1; addr = 32'h20; wd = 32'hA5A5A5A5;
        @(posedge clk); #1;
        chk("rstmid busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("rstmid busy clr", 32'(busy), 32'd0);
        req = 1'b0; we = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("rstmid ready", 32'(ready), 32'd0);
        end
        reset = 1'b0;
        xact0("rd20 kept", 1'b0, 32'h20, 32'h0, 32'h11111111, 1'b0, 1'b0);

        xact0("wr104", 1'b1, 32'h104, 32'h1, 32'h0, 1'b0, 1'b0);
        xact0("rd004 alias", 1'b0, 32'h004, 32'h0, 32'h1, 1'b0, 1'b0);
        xact0("rd21 mis", 1'b0, 32'h21, 32'h0, 32'h0, 1'b1, 1'b0);

        xact0("wr14 scr", 1'b1, 32'h14, 32'h000055AA, 32'h0, 1'b0, 1'b1);
        xact0("rd14", 1'b0, 32'h14, 32'h0, 32'h000055AA, 1'b0, 1'b0);

        req = 1'b1; we = 1'b1; addr = 32'h30; wd = 32'hCAFEF00D;
        q0.push_back(mk(32'h0, 1'b0));
        q0.push_back(mk(32'hCAFEF00D, 1'b0));
        for (int k = 0; k < 7; k++) begin
            @(posedge clk); #1;
            pulse = (k == 2) || (k == 6);
            chk("b2b ready", 32'(ready), 32'(pulse));
            chk("b2b stall", 32'(stall), 32'(!pulse));
            if (k == 2) we = 1'b0;
        end
        req = 1'b0;
        @(posedge clk); #1;

        xact1("d1 wr08", 1'b1, 32'h08, 32'h00000077, 32'h0);
        xact1("d1 rd08", 1'b0, 32'h08, 32'h0, 32'h00000077);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            chk("d1 rd hold", rd1, 32'h00000077);
            chk("d1 no ready", 32'(ready1), 32'd0);
        end

        repeat (2) @(posedge clk);
        #1;
        chk("q0 drained", 32'(q0.size()), 32'd0);
        chk("q1 drained", 32'(q1.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
